// File: rtl/search_pkg.sv
// Shared types for the binary-search scheduler: FSM states and the
// per-key result record returned to the consumer.
package search_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESULT,
    S_DRAIN
  } sched_state_t;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] key;
    logic                  found;
    logic [DEF_ADDR_W-1:0] loc;
    logic                  timeout;
  } result_t;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous key FIFO; pointers wrap modulo QDEPTH and the
// occupancy count carries one extra bit to tell full from empty.
module key_fifo #(
  parameter int DATA_W = 8,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [PW:0] FULL_CNT = QDEPTH[PW:0];

  logic [DATA_W-1:0] mem_q [QDEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW:0]       cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/search_scheduler.sv
// Launches queued keys on the binary-search engine one at a time and
// lends the shared RAM to the table loader between searches.
import search_pkg::*;

module search_scheduler #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int QDEPTH   = 4,
  parameter int WR_BURST = 8,
  parameter int TIMEOUT  = 64
) (
  input  logic              Clock,
  input  logic              Reset_n,
  input  logic              req_valid,
  input  logic [DATA_W-1:0] req_key,
  output logic              req_ready,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_grant,
  input  logic [ADDR_W-1:0] srch_addr,
  output logic              srch_Start,
  output logic              srch_Enable,
  output logic [DATA_W-1:0] srch_A,
  input  logic              srch_Done,
  input  logic              srch_Found,
  input  logic [ADDR_W-1:0] srch_Loc,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_key,
  output logic              res_found,
  output logic [ADDR_W-1:0] res_loc,
  output logic              res_timeout
);

  localparam int BW = $clog2(WR_BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(WR_BURST);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  sched_state_t      state_q, state_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  result_t           res_q, res_d;
  logic              abort_q, abort_d;

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] head;

  assign req_ready = ~fifo_full;
  assign push      = req_valid & req_ready;

  key_fifo #(
    .DATA_W (DATA_W),
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk   (Clock),
    .rst_n (Reset_n),
    .push  (push),
    .pop   (pop),
    .din   (req_key),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    tmo_d       = tmo_q;
    res_d       = res_q;
    abort_d     = 1'b0;
    pop         = 1'b0;
    wr_grant    = 1'b0;
    srch_Start  = 1'b0;
    srch_A      = '0;
    ram_address = srch_addr;
    ram_data    = '0;
    ram_wren    = 1'b0;
    res_valid   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wr_grant    = wr_req &
                      ~(~fifo_empty & (burst_q == BURST_MAX));
        ram_address = wr_addr;
        ram_data    = wr_data;
        ram_wren    = wr_grant;
        if (fifo_empty) begin
          burst_d = '0;
        end else if (wr_grant) begin
          burst_d = burst_q + 1'b1;
        end else begin
          burst_d = '0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        srch_Start = 1'b1;
        srch_A     = head;
        tmo_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        srch_Start = 1'b1;
        srch_A     = head;
        tmo_d      = tmo_q + 1'b1;
        if (srch_Done) begin
          pop           = 1'b1;
          res_d.key     = head;
          res_d.found   = srch_Found;
          res_d.loc     = srch_Found ? srch_Loc : '0;
          res_d.timeout = 1'b0;
          state_d       = S_RESULT;
        end else if (tmo_q == TMO_LAST) begin
          // Engine is stuck: drop Enable next cycle to force it idle.
          pop           = 1'b1;
          res_d.key     = head;
          res_d.found   = 1'b0;
          res_d.loc     = '0;
          res_d.timeout = 1'b1;
          abort_d       = 1'b1;
          state_d       = S_RESULT;
        end
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      burst_q <= '0;
      tmo_q   <= '0;
      res_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      tmo_q   <= tmo_d;
      res_q   <= res_d;
      abort_q <= abort_d;
    end
  end

  assign srch_Enable = ~abort_q;
  assign res_key     = res_q.key;
  assign res_found   = res_q.found;
  assign res_loc     = res_q.loc;
  assign res_timeout = res_q.timeout;

endmodule
